// File: rtl/dense_layer_engine_if.sv
// dense_layer_engine_if
//   Bundles the per-layer run/done handshake and the three read-RAM ports
//   plus the output-buffer write port of dense_layer_engine.
//   slave  : engine side (drives addresses, write port, done/busy).
//   master : sequencer/memory side (drives run and the RAM read data).
//   Signal names match the engine's original port names.
interface dense_layer_engine_if #(
  parameter int unsigned IN_LEN  = 784,
  parameter int unsigned OUT_LEN = 128,
  parameter int unsigned DATA_W  = 16
);
  localparam int unsigned IA = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int unsigned OA = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int unsigned WA = (IN_LEN * OUT_LEN > 1) ? $clog2(IN_LEN * OUT_LEN) : 1;

  logic              run;
  logic              done;
  logic              busy;
  logic [IA-1:0]     act_rd_addr;
  logic [DATA_W-1:0] act_rd_data;
  logic [WA-1:0]     wgt_rd_addr;
  logic [DATA_W-1:0] wgt_rd_data;
  logic [OA-1:0]     bias_rd_addr;
  logic [DATA_W-1:0] bias_rd_data;
  logic              out_wr_en;
  logic [OA-1:0]     out_wr_addr;
  logic [DATA_W-1:0] out_wr_data;

  modport slave (
    input  run, act_rd_data, wgt_rd_data, bias_rd_data,
    output done, busy, act_rd_addr, wgt_rd_addr, bias_rd_addr,
           out_wr_en, out_wr_addr, out_wr_data
  );

  modport master (
    output run, act_rd_data, wgt_rd_data, bias_rd_data,
    input  done, busy, act_rd_addr, wgt_rd_addr, bias_rd_addr,
           out_wr_en, out_wr_addr, out_wr_data
  );
endinterface

// File: rtl/dense_layer_engine.sv
// dense_layer_engine
//   Computes one fully connected layer out[j] = ReLU(bias[j] + sum_i act[i]*w[j][i])
//   with a single time-multiplexed signed fixed-point MAC, in response to a
//   rising edge of the sequencer's run level, and returns a one-cycle done.
//   Ports:
//     clk  : clock
//     rst  : synchronous, active-high reset
//     bus  : dense_layer_engine_if.slave (run/done/busy, act/wgt/bias RAM
//            read ports with 1-cycle latency, output-buffer write port)
//   Build option:
//     DENSE_LAYER_SAT_EN : clamp positive results above the largest DATA_W
//                          signed value instead of wrapping.
module dense_layer_engine #(
  parameter int unsigned IN_LEN  = 784,
  parameter int unsigned OUT_LEN = 128,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FRAC    = 8,
  parameter int unsigned ACC_W   = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  dense_layer_engine_if.slave  bus
);
  localparam int unsigned IA = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int unsigned OA = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int unsigned WA = (IN_LEN * OUT_LEN > 1) ? $clog2(IN_LEN * OUT_LEN) : 1;

  localparam logic [IA-1:0] I_LAST = IA'(IN_LEN - 1);
  localparam logic [OA-1:0] J_LAST = OA'(OUT_LEN - 1);
  localparam logic [WA-1:0] W_STEP = WA'(IN_LEN);

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, DONE} state_e;

  state_e                    state_q;
  logic                      run_q;
  logic [IA-1:0]             i_q;
  logic [OA-1:0]             j_q;
  logic [WA-1:0]             w_base_q;
  logic                      pend_q;   // previous cycle issued a read address
  logic                      first_q;  // that address was i=0 of a neuron
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      out_wr_en_q;
  logic [OA-1:0]             out_wr_addr_q;
  logic [DATA_W-1:0]         out_wr_data_q;
  logic                      done_q;
  logic                      busy_q;

  logic                      start;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   bias_sh;
  logic [DATA_W-1:0]         act_val;

  assign start   = bus.run & ~run_q;
  assign prod    = $signed(bus.act_rd_data) * $signed(bus.wgt_rd_data);
  assign bias_sh = ACC_W'($signed(bus.bias_rd_data)) <<< FRAC;

  always_comb begin
    acc_d = acc_q;
    if (pend_q)
      acc_d = (first_q ? bias_sh : acc_q) + ACC_W'(prod);
  end

  // Activation on acc_d >>> FRAC, taken directly as bit slices of acc_d.
  always_comb begin
    act_val = '0;
    if (!acc_d[ACC_W-1]) begin
`ifdef DENSE_LAYER_SAT_EN
      if (|acc_d[ACC_W-2:FRAC+DATA_W-1])
        act_val = {1'b0, {(DATA_W-1){1'b1}}};
      else
        act_val = acc_d[FRAC +: DATA_W];
`else
      act_val = acc_d[FRAC +: DATA_W];
`endif
    end
  end

  always_ff @(posedge clk) begin
    run_q <= bus.run;
    if (rst) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      w_base_q      <= '0;
      pend_q        <= 1'b0;
      first_q       <= 1'b0;
      acc_q         <= '0;
      out_wr_en_q   <= 1'b0;
      out_wr_addr_q <= '0;
      out_wr_data_q <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      pend_q      <= 1'b0;
      first_q     <= 1'b0;
      out_wr_en_q <= 1'b0;
      done_q      <= 1'b0;
      if ((state_q == MAC || state_q == DRAIN || state_q == WRITE) && !bus.run) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        i_q      <= '0;
        j_q      <= '0;
        w_base_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q  <= MAC;
              busy_q   <= 1'b1;
              i_q      <= '0;
              j_q      <= '0;
              w_base_q <= '0;
            end
          end
          MAC: begin
            pend_q  <= 1'b1;
            first_q <= (i_q == '0);
            acc_q   <= acc_d;
            if (i_q == I_LAST) state_q <= DRAIN;
            else               i_q     <= i_q + IA'(1);
          end
          DRAIN: begin
            acc_q         <= acc_d;
            out_wr_en_q   <= 1'b1;
            out_wr_addr_q <= j_q;
            out_wr_data_q <= act_val;
            state_q       <= WRITE;
          end
          WRITE: begin
            if (j_q == J_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              j_q      <= j_q + OA'(1);
              i_q      <= '0;
              w_base_q <= w_base_q + W_STEP;
              state_q  <= MAC;
            end
          end
          DONE: begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            i_q      <= '0;
            j_q      <= '0;
            w_base_q <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.act_rd_addr  = i_q;
  assign bus.wgt_rd_addr  = w_base_q + WA'(i_q);
  assign bus.bias_rd_addr = j_q;
  assign bus.out_wr_addr  = out_wr_addr_q;
  assign bus.out_wr_data  = out_wr_data_q;
  assign bus.done         = done_q;
  // The write strobe is registered on entry to WRITE; gating it with run
  // drops a write whose cycle coincides with an abort.
  assign bus.out_wr_en    = out_wr_en_q & bus.run;
  // The start cycle itself already counts as busy.
  assign bus.busy         = busy_q | (start & ~rst & (state_q == IDLE));
endmodule
